// File: rtl/core_pipe_mem.sv
// core_pipe_mem: memory/writeback stage; serialises loads/stores, formats load data, drives the regfile write port and trap pulses.
module core_pipe_mem #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [4:0]      s_rd,
    input  logic [XLEN-1:0] s_result,
    input  logic [XLEN-1:0] s_addr,
    input  logic [XLEN-1:0] s_wdata,
    input  logic            s_load,
    input  logic            s_store,
    input  logic [1:0]      s_size,
    input  logic            s_unsigned,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_addr,
    output logic [7:0]      dmem_strb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic            dmem_rsp_error,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            trap_valid,
    output logic [3:0]      trap_cause
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t state, state_nx;
    logic [4:0] r_rd;
    logic [1:0] r_size;
    logic r_uns;
    logic [2:0] r_off;
    logic acc, is_mem, mis;
    logic [2:0] align;
    logic [7:0] mask;
    logic [XLEN-1:0] sh, ld_data;
    assign s_ready = state == IDLE;
    assign dmem_req = state == REQ;
    always_comb begin
        acc = s_valid && s_ready;
        is_mem = s_load || s_store;
        align = {s_size == 2'd3, s_size[1], |s_size};
        mis = |(s_addr[2:0] & align);
        mask = s_size == 2'd0 ? 8'h01 : s_size == 2'd1 ? 8'h03 : s_size == 2'd2 ? 8'h0f : 8'hff;
        state_nx = state;
        state_nx = (state == IDLE && acc && is_mem && !mis) ? REQ :
                   (state == REQ && dmem_gnt) ? RSP :
                   (state == RSP && dmem_rsp_valid) ? IDLE : state;
        sh = dmem_rsp_rdata >> {r_off, 3'b000};
        ld_data = r_size == 2'd0 ? {{56{sh[7] & ~r_uns}}, sh[7:0]} :
                  r_size == 2'd1 ? {{48{sh[15] & ~r_uns}}, sh[15:0]} :
                  r_size == 2'd2 ? {{32{sh[31] & ~r_uns}}, sh[31:0]} : sh;
    end
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= IDLE;
            r_rd <= '0;
            r_size <= '0;
            r_uns <= 1'b0;
            r_off <= '0;
            dmem_wen <= 1'b0;
            dmem_addr <= '0;
            dmem_strb <= '0;
            dmem_wdata <= '0;
            rf_wen <= 1'b0;
            rf_addr <= '0;
            rf_wdata <= '0;
            trap_valid <= 1'b0;
            trap_cause <= '0;
        end else begin
            state <= state_nx;
            rf_wen <= 1'b0;
            trap_valid <= 1'b0;
            if (acc && !is_mem) begin
                rf_wen <= s_rd != 5'd0;
                rf_addr <= s_rd;
                rf_wdata <= s_result;
            end else if (acc && mis) begin
                trap_valid <= 1'b1;
                trap_cause <= s_store ? 4'd6 : 4'd4;
            end else if (acc) begin
                r_rd <= s_rd;
                r_size <= s_size;
                r_uns <= s_unsigned;
                r_off <= s_addr[2:0];
                dmem_wen <= s_store;
                dmem_addr <= {s_addr[XLEN-1:3], 3'b000};
                dmem_strb <= mask << s_addr[2:0];
                dmem_wdata <= s_wdata << {s_addr[2:0], 3'b000};
            end
            // a faulting response always traps; only successful loads write back
            if (state == RSP && dmem_rsp_valid && dmem_rsp_error) begin
                trap_valid <= 1'b1;
                trap_cause <= dmem_wen ? 4'd7 : 4'd5;
            end else if (state == RSP && dmem_rsp_valid && !dmem_wen) begin
                rf_wen <= r_rd != 5'd0;
                rf_addr <= r_rd;
                rf_wdata <= ld_data;
            end
        end
    end
endmodule
